// File: rtl/uart_cmd_sequencer.sv
// Sends A, B, OP bytes to a UART transmitter with fixed inter-byte spacing, then waits for the result byte.
// Define SEQ_TIMEOUT_EN to build the result-wait timeout (otherwise o_timeout is tied low).
module uart_cmd_sequencer #(
  parameter int unsigned NB_BITS        = 8,
  parameter int unsigned GAP_CYCLES     = 26080,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_start,
  input  logic [NB_BITS-1:0] i_A,
  input  logic [NB_BITS-1:0] i_B,
  input  logic [NB_BITS-1:0] i_OP,
  input  logic [NB_BITS-1:0] i_result,
  input  logic               i_result_valid,
  output logic               o_tx_start,
  output logic [NB_BITS-1:0] o_data,
  output logic               o_busy,
  output logic [NB_BITS-1:0] o_result,
  output logic               o_result_valid,
  output logic               o_timeout
);

  typedef enum logic [2:0] {IDLE, SEND, GAP, WAIT_RES, DONE} state_e;

  localparam int unsigned    GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  state_e               state_q, state_d;
  logic [1:0]           idx_q, idx_d;
  logic [GAP_W-1:0]     gap_cnt_q, gap_cnt_d;
  logic [NB_BITS-1:0]   snap_a_q, snap_a_d;
  logic [NB_BITS-1:0]   snap_b_q, snap_b_d;
  logic [NB_BITS-1:0]   snap_op_q, snap_op_d;
  logic [NB_BITS-1:0]   data_q, data_d;
  logic [NB_BITS-1:0]   result_q, result_d;
  logic [NB_BITS-1:0]   send_byte;

`ifdef SEQ_TIMEOUT_EN
  localparam int unsigned    TMO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             timeout_q, timeout_d;
  assign o_timeout = timeout_q;
`else
  assign o_timeout = 1'b0;
`endif

  always_comb begin
    case (idx_q)
      2'd0:    send_byte = snap_a_q;
      2'd1:    send_byte = snap_b_q;
      default: send_byte = snap_op_q;
    endcase
  end

  // o_data shows the selected byte during SEND and the registered copy afterwards, so it holds between launches.
  assign o_tx_start     = (state_q == SEND);
  assign o_data         = o_tx_start ? send_byte : data_q;
  assign o_busy         = (state_q != IDLE);
  assign o_result       = result_q;
  assign o_result_valid = (state_q == DONE);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    gap_cnt_d = gap_cnt_q;
    snap_a_d  = snap_a_q;
    snap_b_d  = snap_b_q;
    snap_op_d = snap_op_q;
    data_d    = data_q;
    result_d  = result_q;
`ifdef SEQ_TIMEOUT_EN
    tmo_cnt_d = tmo_cnt_q;
    timeout_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (i_start) begin
          snap_a_d  = i_A;
          snap_b_d  = i_B;
          snap_op_d = i_OP;
          idx_d     = '0;
          state_d   = SEND;
        end
      end
      SEND: begin
        data_d    = send_byte;
        gap_cnt_d = '0;
        state_d   = GAP;
      end
      GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          if (idx_q < 2'd2) begin
            idx_d   = idx_q + 2'd1;
            state_d = SEND;
          end else begin
`ifdef SEQ_TIMEOUT_EN
            tmo_cnt_d = '0;
`endif
            state_d = WAIT_RES;
          end
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      WAIT_RES: begin
        // A result arriving on the expiry cycle wins over the timeout.
        if (i_result_valid) begin
          result_d = i_result;
          state_d  = DONE;
        end
`ifdef SEQ_TIMEOUT_EN
        else if (tmo_cnt_q == TMO_LAST) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
`endif
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      gap_cnt_q <= '0;
      snap_a_q  <= '0;
      snap_b_q  <= '0;
      snap_op_q <= '0;
      data_q    <= '0;
      result_q  <= '0;
`ifdef SEQ_TIMEOUT_EN
      tmo_cnt_q <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      gap_cnt_q <= gap_cnt_d;
      snap_a_q  <= snap_a_d;
      snap_b_q  <= snap_b_d;
      snap_op_q <= snap_op_d;
      data_q    <= data_d;
      result_q  <= result_d;
`ifdef SEQ_TIMEOUT_EN
      tmo_cnt_q <= tmo_cnt_d;
      timeout_q <= timeout_d;
`endif
    end
  end

endmodule
